// File: rtl/io_input_cond.sv
// Input conditioning for the memory-mapped switch/button inputs: two-flop synchronizers,
// tick-sampled debounce, button press pulses and write-1-to-clear sticky press flags.
module io_input_cond #(
    parameter int SW_WIDTH       = 32,
    parameter int BTN_WIDTH      = 4,
    parameter int TICK_DIV       = 500000,
    parameter int STABLE_SAMPLES = 4,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [SW_WIDTH-1:0]  i_sw_raw,
    input  logic [BTN_WIDTH-1:0] i_btn_raw,
    input  logic [BTN_WIDTH-1:0] i_btn_clr,
    output logic [SW_WIDTH-1:0]  o_io_sw,
    output logic [BTN_WIDTH-1:0] o_io_btn,
    output logic [BTN_WIDTH-1:0] o_btn_pulse,
    output logic [BTN_WIDTH-1:0] o_btn_press
);

    localparam int CH = SW_WIDTH + BTN_WIDTH;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0]             r_cnt;
    logic                      w_tick;
    logic [SW_WIDTH-1:0]       r_sw_s1, r_sw_s2;
    logic [BTN_WIDTH-1:0]      r_btn_s1, r_btn_s2;
    logic [BTN_WIDTH-1:0]      w_btn_sync;
    logic [CH-1:0]             w_sync;
    logic [STABLE_SAMPLES-1:0] r_hist     [CH];
    logic [STABLE_SAMPLES-1:0] w_hist_nxt [CH];
    logic [CH-1:0]             r_lvl;
    logic [CH-1:0]             w_lvl_nxt;
    logic [BTN_WIDTH-1:0]      w_btn_rise;
    logic [BTN_WIDTH-1:0]      r_pulse;
    logic [BTN_WIDTH-1:0]      r_press;

    assign w_tick = (r_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
        end else begin
            r_sw_s1  <= i_sw_raw;
            r_sw_s2  <= r_sw_s1;
            r_btn_s1 <= i_btn_raw;
            r_btn_s2 <= r_btn_s1;
        end
    end

    // Buttons are carried internally as 1 = pressed regardless of pin polarity.
    assign w_btn_sync = (BTN_ACTIVE_LOW != 0) ? ~r_btn_s2 : r_btn_s2;
    assign w_sync     = {w_btn_sync, r_sw_s2};

    always_comb begin
        w_lvl_nxt = r_lvl;
        for (int ch = 0; ch < CH; ch++) begin
            w_hist_nxt[ch] = {r_hist[ch][STABLE_SAMPLES-2:0], w_sync[ch]};
            if (&w_hist_nxt[ch]) begin
                w_lvl_nxt[ch] = 1'b1;
            end else if (~|w_hist_nxt[ch]) begin
                w_lvl_nxt[ch] = 1'b0;
            end
        end
    end

    assign w_btn_rise = w_lvl_nxt[CH-1:SW_WIDTH] & ~r_lvl[CH-1:SW_WIDTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int ch = 0; ch < CH; ch++) begin
                r_hist[ch] <= '0;
            end
            r_lvl   <= '0;
            r_pulse <= '0;
        end else if (w_tick) begin
            for (int ch = 0; ch < CH; ch++) begin
                r_hist[ch] <= w_hist_nxt[ch];
            end
            r_lvl   <= w_lvl_nxt;
            r_pulse <= w_btn_rise;
        end else begin
            r_pulse <= '0;
        end
    end

    // A pulse sets the flag on the edge that ends the pulse cycle; set beats a same-cycle clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_press <= '0;
        end else begin
            r_press <= (r_press & ~i_btn_clr) | r_pulse;
        end
    end

    assign o_io_sw     = r_lvl[SW_WIDTH-1:0];
    assign o_io_btn    = r_lvl[CH-1:SW_WIDTH];
    assign o_btn_pulse = r_pulse;
    assign o_btn_press = r_press;

endmodule
